// File: rtl/ex_mult_div_if.sv
// ex_mult_div_if: request, MTHI/MTLO and HI/LO result bundle of the EX-stage multiply/divide unit
interface ex_mult_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             stall_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
                  input  busy, done, stall_req, hi, lo);
  modport slave  (input  start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
                  output busy, done, stall_req, hi, lo);
endinterface

// File: rtl/ex_mult_div_unit.sv
// ex_mult_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU writing the HI/LO registers
module ex_mult_div_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  ex_mult_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH-1:0] m, hi_r, lo_r, a_abs, b_abs, hi_fix, lo_fix;
  logic [WIDTH:0] msum, trial;
  logic is_div, neg_q, neg_r, div_zero, a_neg, b_neg, accept;
  // A zero divisor keeps the dividend raw so the shift-subtract yields all-ones / dividend
  assign div_zero = bus.op[1] && bus.operand_b == '0;
  assign a_neg = !bus.op[0] && bus.operand_a[WIDTH-1] && !div_zero;
  assign b_neg = !bus.op[0] && bus.operand_b[WIDTH-1];
  assign a_abs = a_neg ? -bus.operand_a : bus.operand_a;
  assign b_abs = b_neg ? -bus.operand_b : bus.operand_b;
  assign accept = state == IDLE && bus.start && !bus.flush;
  // acc holds {partial, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : '0};
  assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, m};
  assign prod_fix = neg_q ? -acc : acc;
  assign hi_fix = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_fix = is_div ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod_fix[WIDTH-1:0];
  always_comb begin
    next = IDLE;
    next = (state != IDLE && bus.flush) ? IDLE :
           state == IDLE ? (accept ? CALC : IDLE) :
           state == CALC ? (cnt == CW'(WIDTH-1) ? FIX : CALC) :
           state == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      m <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (accept) begin
        cnt <= '0;
        is_div <= bus.op[1];
        m <= bus.op[1] ? b_abs : a_abs;
        acc <= {{WIDTH{1'b0}}, bus.op[1] ? a_abs : b_abs};
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
      if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? (trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                      : {msum, acc[WIDTH-1:1]};
      end
      if (state == FIX && !bus.flush) begin
        hi_r <= hi_fix;
        lo_r <= lo_fix;
      end else if (state == IDLE || state == DONE) begin
        if (bus.hi_we) hi_r <= bus.wdata;
        if (bus.lo_we) lo_r <= bus.wdata;
      end
    end
  end
  assign bus.busy = state == CALC || state == FIX;
  assign bus.done = state == DONE;
  assign bus.stall_req = bus.start | bus.busy;
  assign bus.hi = hi_r;
  assign bus.lo = lo_r;
endmodule

// File: tb/tb_ex_mult_div_unit.sv
// tb_ex_mult_div_unit: directed vectors with a done-driven scoreboard for the multiply/divide unit
module tb_ex_mult_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  string name_q[$];
  ex_mult_div_if #(.WIDTH(32)) bus();
  ex_mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.done) begin
      if (exp_q.size() == 0) check64("unexpected_done", {bus.hi, bus.lo}, 64'hx);
      else check64(name_q.pop_front(), {bus.hi, bus.lo}, exp_q.pop_front());
    end
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input string nm, input bit poke);
    int n, bc;
    @(negedge clk);
    while (bus.done) @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = ~op;
    bus.operand_a = ~a;
    bus.operand_b = b + 32'd1;
    n = 0;
    bc = int'(bus.busy);
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
      bc += int'(bus.busy);
      bus.start = poke && (n == 5 || n == 20);
    end
    bus.start = 1'b0;
    check_int({nm, "_latency"}, n, 33);
    check_int({nm, "_busy_cycles"}, bc, 33);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int dc;
    bus.start = 0; bus.op = 0; bus.operand_a = 0; bus.operand_b = 0;
    bus.flush = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check64("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    check_int("reset_busy_done", {bus.busy, bus.done}, 0);
    check_int("idle_stall_low", bus.stall_req, 0);
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max", 1'b1);
    run(2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, "mult_neg3x7", 1'b0);
    run(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 64'h00000000_00000006, "mult_negxneg", 1'b0);
    run(2'b01, 32'h00010000, 32'h00010000, 64'h00000001_00000000, "multu_carry", 1'b0);
    run(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_neg7by2", 1'b0);
    run(2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7byneg2", 1'b0);
    run(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, "divu_100by7", 1'b1);
    run(2'b11, 32'h1234, 32'd0, 64'h00001234_FFFFFFFF, "divu_by0", 1'b0);
    run(2'b10, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, "div_neg_by0", 1'b0);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_min_by_m1", 1'b0);
    @(negedge clk);
    while (bus.done) @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'hAAAA;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5555;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check64("mthi_mtlo_idle", {bus.hi, bus.lo}, 64'h0000AAAA_00005555);
    bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd3; bus.operand_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      bus.hi_we = n == 3; bus.lo_we = n == 3; bus.wdata = 32'hDEAD;
      bus.start = n == 6;
      if (n == 5) check_int("stall_while_busy", bus.stall_req, 1);
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_int("flush_busy_low", bus.busy, 0);
    dc = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      dc += int'(bus.done);
    end
    check_int("flush_no_done", dc, 0);
    check64("flush_keeps_hilo", {bus.hi, bus.lo}, 64'h0000AAAA_00005555);
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    #1 check_int("stall_tracks_start", bus.stall_req, 1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check_int("flush_beats_start", bus.busy, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 32'hFFFFFFF9; bus.operand_b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check64("async_rst_hilo", {bus.hi, bus.lo}, 64'h0);
    check_int("async_rst_busy_done", {bus.busy, bus.done}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.lo_we = 1'b1; bus.wdata = 32'hCAFE;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check64("mtlo_cafe", {bus.hi, bus.lo}, 64'h00000000_0000CAFE);
    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
